// File: rtl/prio_enc_disp_if.sv
// Request/readout bundle for prio_enc_disp: raw switches and advance strobe in,
// granted index, status and two seven-segment digits out.
interface prio_enc_disp_if #(
    parameter int N = 16
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] x;
    logic         adv;
    logic [W-1:0] idx;
    logic         valid;
    logic         changed;
    logic [6:0]   seg_lo;
    logic [6:0]   seg_hi;

    modport master (output x, adv, input idx, valid, changed, seg_lo, seg_hi);
    modport slave  (input x, adv, output idx, valid, changed, seg_lo, seg_hi);
endinterface

// File: rtl/prio_enc_disp.sv
// Debounced N-way priority encoder (fixed or round-robin) with registered
// grant index, change strobe and two-digit active-low hex readout.
module prio_enc_disp #(
    parameter int N      = 16,
    parameter int STABLE = 4,
    parameter bit MODE   = 1'b0
) (
    input  logic            clk,
    input  logic            clrn,
    prio_enc_disp_if.slave  bus
);
    localparam int         W       = $clog2(N);
    localparam logic [W-1:0] PTR_TOP = W'(N - 1);
    localparam logic [7:0] STB     = 8'(STABLE);
    localparam logic [6:0] BLANK   = 7'b1111111;

    logic [N-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, xs_q, xs_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [W-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic         valid_q, valid_d, changed_q, changed_d;
    logic [6:0]   seg_lo_q, seg_lo_d, seg_hi_q, seg_hi_d;

    logic         hit;
    logic [W-1:0] gnt;
    logic [7:0]   idx_ext;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Synchroniser and debounce: a vector is accepted only after holding STABLE cycles.
    always_comb begin
        s1_d   = bus.x;
        s2_d   = s1_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        xs_d   = xs_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q < STB) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == STB - 8'd1) xs_d = cand_q;
        end
    end

    // Downward search from ptr, wrapping 0 -> N-1; first set bit wins.
    always_comb begin
        int           j;
        logic [W-1:0] jw;
        hit = 1'b0;
        gnt = '0;
        j   = 0;
        jw  = '0;
        for (int k = 0; k < N; k++) begin
            j  = (int'(ptr_q) >= k) ? int'(ptr_q) - k : int'(ptr_q) + N - k;
            jw = W'(j);
            if (!hit && xs_q[jw]) begin
                hit = 1'b1;
                gnt = jw;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE && bus.adv && valid_q)
            ptr_d = (idx_q == '0) ? PTR_TOP : idx_q - W'(1);
    end

    always_comb begin
        valid_d   = hit;
        idx_d     = hit ? gnt : idx_q;
        changed_d = (idx_d != idx_q) || (valid_d != valid_q);
        idx_ext          = '0;
        idx_ext[W-1:0]   = idx_d;
        seg_lo_d  = valid_d ? hex7(idx_ext[3:0]) : BLANK;
        seg_hi_d  = valid_d ? hex7(idx_ext[7:4]) : BLANK;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            xs_q      <= '0;
            ptr_q     <= PTR_TOP;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            seg_lo_q  <= BLANK;
            seg_hi_q  <= BLANK;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            xs_q      <= xs_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            seg_lo_q  <= seg_lo_d;
            seg_hi_q  <= seg_hi_d;
        end
    end

    assign bus.idx     = idx_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
    assign bus.seg_lo  = seg_lo_q;
    assign bus.seg_hi  = seg_hi_q;
endmodule

// File: tb/tb_prio_enc_disp.sv
// Bench for prio_enc_disp: a fixed-priority and a round-robin instance share the
// same switch stimulus; expected readouts are queued with their due cycle.
module tb_prio_enc_disp;
    localparam int N = 16;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    prio_enc_disp_if #(.N(N)) if0 ();
    prio_enc_disp_if #(.N(N)) if1 ();

    prio_enc_disp #(.N(N), .STABLE(4), .MODE(1'b0)) u_fix (.clk(clk), .clrn(clrn), .bus(if0.slave));
    prio_enc_disp #(.N(N), .STABLE(4), .MODE(1'b1)) u_rr  (.clk(clk), .clrn(clrn), .bus(if1.slave));

    typedef struct { int due; int dut; logic v; logic [3:0] i; } exp_t;
    typedef struct { logic [15:0] x; logic v; logic [3:0] i; } vec_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0, cyc = 0, chg0 = 0, chg1 = 0;
    logic       ev0 = 1'b0, ev1 = 1'b0;
    logic [3:0] ei0 = '0, ei1 = '0;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[h];
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_out(input int d, input logic v, input logic [3:0] i);
        string t;
        t = (d == 0) ? "fix" : "rr";
        if (d == 0) begin
            chk({t, ".valid"}, 16'(if0.valid), 16'(v));
            chk({t, ".idx"}, 16'(if0.idx), 16'(i));
            chk({t, ".seg_lo"}, 16'(if0.seg_lo), 16'(v ? seg_of(i) : 7'h7F));
            chk({t, ".seg_hi"}, 16'(if0.seg_hi), 16'(v ? seg_of(4'h0) : 7'h7F));
        end else begin
            chk({t, ".valid"}, 16'(if1.valid), 16'(v));
            chk({t, ".idx"}, 16'(if1.idx), 16'(i));
            chk({t, ".seg_lo"}, 16'(if1.seg_lo), 16'(v ? seg_of(i) : 7'h7F));
            chk({t, ".seg_hi"}, 16'(if1.seg_hi), 16'(v ? seg_of(4'h0) : 7'h7F));
        end
    endtask

    task automatic chk_reset();
        chk("rst.fix.valid", 16'(if0.valid), 16'h0);
        chk("rst.fix.idx", 16'(if0.idx), 16'h0);
        chk("rst.fix.seg_lo", 16'(if0.seg_lo), 16'h7F);
        chk("rst.fix.seg_hi", 16'(if0.seg_hi), 16'h7F);
        chk("rst.fix.changed", 16'(if0.changed), 16'h0);
        chk("rst.rr.valid", 16'(if1.valid), 16'h0);
        chk("rst.rr.idx", 16'(if1.idx), 16'h0);
        chk("rst.rr.seg_lo", 16'(if1.seg_lo), 16'h7F);
        chk("rst.rr.seg_hi", 16'(if1.seg_hi), 16'h7F);
        chk("rst.rr.changed", 16'(if1.changed), 16'h0);
    endtask

    task automatic push(input int d, input logic v, input logic [3:0] i, input int due);
        exp_t e;
        e.due = due; e.dut = d; e.v = v; e.i = i;
        sb.push_back(e);
    endtask

    // One negedge: count change pulses and retire scoreboard entries that are due.
    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (if0.changed) chg0++;
            if (if1.changed) chg1++;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check_out(e.dut, e.v, e.i);
            end
        end
    endtask

    task automatic wait_sb(input int limit);
        int t;
        t = 0;
        while (sb.size() > 0 && t < limit) begin
            step(1);
            t++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_timeout: got %0d pending want 0 (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
    endtask

    task automatic drive_x(input logic [15:0] v);
        if0.x = v;
        if1.x = v;
    endtask

    task automatic drive_adv(input logic a);
        if0.adv = a;
        if1.adv = a;
    endtask

    // Outputs must still hold old values at lat-1 and show new ones exactly at lat.
    task automatic expect_at(input int lat, input logic v0, input logic [3:0] i0,
                             input logic v1, input logic [3:0] i1);
        int c0, c1;
        logic [3:0] n0, n1;
        logic x0, x1;
        c0 = chg0; c1 = chg1;
        n0 = v0 ? i0 : ei0;
        n1 = v1 ? i1 : ei1;
        x0 = (v0 != ev0) || (n0 != ei0);
        x1 = (v1 != ev1) || (n1 != ei1);
        push(0, ev0, ei0, cyc + lat - 1);
        push(1, ev1, ei1, cyc + lat - 1);
        push(0, v0, n0, cyc + lat);
        push(1, v1, n1, cyc + lat);
        ev0 = v0; ei0 = n0; ev1 = v1; ei1 = n1;
        if (lat == 2) begin
            step(1);
            drive_adv(1'b0);
        end
        wait_sb(lat + 4);
        step(1);
        chk("chg_count.fix", 16'(chg0 - c0), 16'(x0));
        chk("chg_count.rr", 16'(chg1 - c1), 16'(x1));
    endtask

    task automatic apply_x(input logic [15:0] v, input logic v0, input logic [3:0] i0,
                           input logic v1, input logic [3:0] i1);
        drive_x(v);
        expect_at(8, v0, i0, v1, i1);
    endtask

    task automatic adv_pulse(input logic v0, input logic [3:0] i0,
                             input logic v1, input logic [3:0] i1);
        drive_adv(1'b1);
        expect_at(2, v0, i0, v1, i1);
    endtask

    initial begin
        vec_t vt [7];
        int   c0, c1;
        vt = '{'{16'h0421, 1'b1, 4'd10}, '{16'h0001, 1'b1, 4'd0},
               '{16'h8000, 1'b1, 4'd15}, '{16'h00F0, 1'b1, 4'd7},
               '{16'h0000, 1'b0, 4'd7},  '{16'h0100, 1'b1, 4'd8},
               '{16'h1234, 1'b1, 4'd12}};

        clrn = 1'b0;
        drive_x(16'hFFFF);
        drive_adv(1'b0);
        step(3);
        chk_reset();
        clrn = 1'b1;
        expect_at(8, 1'b1, 4'd15, 1'b1, 4'd15);

        foreach (vt[k]) apply_x(vt[k].x, vt[k].v, vt[k].i, vt[k].v, vt[k].i);

        // Bouncing input must never be accepted.
        apply_x(16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
        c0 = chg0; c1 = chg1;
        for (int r = 0; r < 4; r++) begin
            drive_x(16'h0008); step(3);
            drive_x(16'h0000); step(3);
        end
        chk("bounce.chg.fix", 16'(chg0 - c0), 16'h0);
        chk("bounce.chg.rr", 16'(chg1 - c1), 16'h0);
        chk("bounce.valid", 16'(if0.valid), 16'h0);
        apply_x(16'h0008, 1'b1, 4'd3, 1'b1, 4'd3);

        // Fixed ignores adv; round-robin steps 10 -> 5 -> 0 -> 10 -> 5.
        apply_x(16'h0421, 1'b1, 4'd10, 1'b1, 4'd10);
        adv_pulse(1'b1, 4'd10, 1'b1, 4'd5);
        adv_pulse(1'b1, 4'd10, 1'b1, 4'd0);
        adv_pulse(1'b1, 4'd10, 1'b1, 4'd10);
        adv_pulse(1'b1, 4'd10, 1'b1, 4'd5);

        // Drop to zero holds idx; adv while invalid must leave ptr at 9.
        apply_x(16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
        adv_pulse(1'b0, 4'd0, 1'b0, 4'd0);
        apply_x(16'h0421, 1'b1, 4'd10, 1'b1, 4'd5);

        // Reset in the middle of a debounce count.
        drive_x(16'h8000);
        step(4);
        clrn = 1'b0;
        #1;
        chk_reset();
        ev0 = 1'b0; ei0 = '0; ev1 = 1'b0; ei1 = '0;
        step(2);
        clrn = 1'b1;
        expect_at(8, 1'b1, 4'd15, 1'b1, 4'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/prio_enc_disp.md
# prio_enc_disp

Parametrised, registered priority encoder with input synchronisation, debounce, and two-digit seven-segment readout. It generalises the lab's 8-to-3 encoder/display pair:
- N request lines instead of 8.
- Glitch-free acceptance of switch inputs.
- Selectable fixed or round-robin priority.
- A one-cycle change strobe.

It sits between the board slide switches and the HEX displays, and feeds `idx`/`valid` to downstream logic.

## Interface
- `N`, 16, number of request lines; legal 2..256; `W = $clog2(N)`.
- `STABLE`, 4, consecutive cycles a synchronised input vector must hold before acceptance; legal 1..255.
- `MODE`, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- `clk`  in  1  system clock; all state on rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `x`  in  N  raw request vector, asynchronous to `clk`.
- `adv`  in  1  synchronous round-robin advance strobe; ignored when `MODE`=0.
- `idx`  out  W  index of granted request.
- `valid`  out  1  at least one accepted request is set.
- `changed`  out  1  one-cycle pulse when `idx` or `valid` changes.
- `seg_lo`  out  7  hex digit `idx[3:0]`, active-low, bit 0 = a … bit 6 = g.
- `seg_hi`  out  7  hex digit `idx[7:4]` (zero-extended), same encoding.

## Operation
- **Synchroniser:** two flops, `s1` and `s2`, on all N bits.
- **Debounce:**
  - Registers `cand` (N bits) and `cnt` (8 bits).
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Otherwise, if `cnt < STABLE`: `cnt <= cnt+1`. When this increment takes `cnt` from `STABLE-1` to `STABLE`, `xs <= cand` (the accepted vector).
  - `cnt` saturates at `STABLE`. A vector that changes before reaching `STABLE` is never accepted.
- **Search pointer `ptr` (W bits):**
  - `MODE`=0: `ptr` is held at N-1.
  - `MODE`=1: `ptr` resets to N-1.
- **Encode (combinational from `xs`, `ptr`; result registered):**
  - Search downward from `ptr`, wrapping from 0 to N-1. The first set bit of `xs` is the grant.
  - `MODE`=0 therefore yields the highest set index.
  - No bit set: `valid <= 0`, and `idx` holds its previous value.
- **Advance (`MODE`=1 only):**
  - On an `adv`=1 edge with `valid`=1: `ptr <= (idx==0) ? N-1 : idx-1`.
  - `adv` with `valid`=0 is ignored.
  - `adv` held high advances once per cycle.
- **Change strobe:** `changed <= 1` for exactly the cycle in which the registered `idx` or `valid` differs from its previous registered value.
- **Display:**
  - Hex codes 0-F, in order: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - When `valid`=0, both digits are blank (1111111).
  - Segments are registered in the same cycle as `idx`.
- **Reset values:**
  - Internal: `s1`, `s2`, `cand`, `xs`, `cnt` = 0; `ptr` = N-1.
  - Outputs: `idx` = 0, `valid` = 0, `changed` = 0, `seg_lo` = `seg_hi` = 1111111.

## Timing
- **Input latency:** `x` first sampled new at edge e0 → `xs` loads at e(2+STABLE) → `idx`/`valid`/`seg`/`changed` update at e(3+STABLE). With the defaults this is edge e7.
- **Advance latency:** `adv` sampled at edge e → `ptr` updates at e → outputs update at e+1.
- **Simultaneous `xs` load and `ptr` update:** both take effect. The next edge's output uses the new `xs` and the new `ptr`.
- **Wrap-around:** the search wraps from index 0 to N-1. With `ptr`=0, a request at N-1 is found after bit 0.
- **Reset mid-operation:** `clrn` low clears all state immediately, independent of `clk`. The debounce restarts from `cnt`=0 after release, and the first output update occurs no earlier than e(3+STABLE) after release.
- **Width:** `idx` is W bits. For N ≤ 16, `seg_hi` always shows 0 while `valid`=1.

## Test plan
- **Reset:** assert `clrn`=0 with `x`=16'hFFFF → `valid`=0, `idx`=0, `seg_lo`=`seg_hi`=1111111, `changed`=0. Release; `x` stays 16'hFFFF → at release+7: `idx`=15, `seg_lo`=0001110, `seg_hi`=1000000, one `changed` pulse.
- **Debounce:** N=16, STABLE=4. Toggle `x` between 16'h0008 and 16'h0000 every 3 cycles → `valid` never rises. Hold 16'h0008 → `idx`=3, `seg_lo`=0110000 exactly 7 cycles after the first sampling edge.
- **Fixed priority:** `MODE`=0, `x`=16'h0421 → `idx`=10; pulse `adv` → no change, no `changed` pulse.
- **Round-robin:** `MODE`=1, `x`=16'h0421 → `idx` 10. Each `adv` then steps `idx` 10→5→0→10 (wrap), each update 1 cycle after its `adv`, with one `changed` pulse per step.
- **Drop to zero:** from `idx`=5, `valid`=1, set `x`=0 → after 7 cycles `valid`=0, `idx` stays 5, segments blank, one `changed` pulse. An `adv` while `valid`=0 leaves `ptr` unchanged.
- **Reset mid-count:** assert `clrn` at cycle 4 of a debounce → all outputs at reset values. After release, the accepted output appears 7 cycles after the first post-release sampling edge.
